// File: rtl/manchester_tx_ctrl_if.sv
// Byte-source / line-side bundle of the Manchester frame sequencer.
// The master is the byte producer; the slave is the sequencer itself.
interface manchester_tx_ctrl_if;
    logic       start;
    logic [7:0] data_in;
    logic       data_valid;
    logic       data_ready;
    logic       manch_out;
    logic       tx_en;
    logic       busy;
    logic       done;

    modport master (
        output start,
        output data_in,
        output data_valid,
        input  data_ready,
        input  manch_out,
        input  tx_en,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  data_in,
        input  data_valid,
        output data_ready,
        output manch_out,
        output tx_en,
        output busy,
        output done
    );
endinterface

// File: rtl/manchester_tx_ctrl.sv
// Manchester transmit frame sequencer.
// Frame = preamble (1,0,1,0,...), data bytes MSB first, then an idle END gap.
// Bytes arrive through a one-byte holding register so the producer can refill
// while the current byte is still being shifted out. The line is IEEE coded:
// a 0 is high->low, a 1 is low->high; every half-bit lasts DIV clocks.
module manchester_tx_ctrl #(
    parameter int DIV           = 4,
    parameter int PREAMBLE_BITS = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    manchester_tx_ctrl_if.slave bus
);
    // Timer is shared between half-bit timing (0..DIV-1) and the END gap (0..2*DIV-1).
    localparam int TW      = $clog2(2 * DIV);
    localparam int CNT_MAX = (PREAMBLE_BITS > 8) ? PREAMBLE_BITS : 8;
    localparam int BW      = $clog2(CNT_MAX);

    localparam logic [TW-1:0] HALF_LAST = TW'(DIV - 1);
    localparam logic [TW-1:0] END_LAST  = TW'(2 * DIV - 1);
    localparam logic [BW-1:0] PRE_LAST  = BW'(PREAMBLE_BITS - 1);
    localparam logic [BW-1:0] BYTE_LAST = BW'(7);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_PREAMBLE = 2'd1,
        S_DATA     = 2'd2,
        S_END      = 2'd3
    } state_t;

    state_t          state_r;
    logic [TW-1:0]   timer_r;
    logic            half_r;        // 0 = first half of the bit, 1 = second half
    logic [BW-1:0]   bit_cnt_r;
    logic [7:0]      shift_r;
    logic [7:0]      hold_r;
    logic            hold_full_r;
    logic            manch_out_r;
    logic            tx_en_r;
    logic            busy_r;
    logic            done_r;

    logic            data_ready_s;
    logic            cur_bit_s;
    logic            last_bit_s;

    // Line level for a bit value in a given half (IEEE: first half is the inverse).
    function automatic logic line_level(input logic bit_val, input logic second_half);
        return second_half ? bit_val : ~bit_val;
    endfunction

    assign data_ready_s = ~hold_full_r && (state_r != S_END);

    // Preamble bit n is 1 for even n, so its value is the inverted LSB of the count.
    assign cur_bit_s  = (state_r == S_DATA) ? shift_r[7] : ~bit_cnt_r[0];
    assign last_bit_s = (state_r == S_DATA) ? (bit_cnt_r == BYTE_LAST)
                                            : (bit_cnt_r == PRE_LAST);

    assign bus.data_ready = data_ready_s;
    assign bus.manch_out  = manch_out_r;
    assign bus.tx_en      = tx_en_r;
    assign bus.busy       = busy_r;
    assign bus.done       = done_r;

    // Frame sequencer: byte capture, half-bit timing, state and registered line outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= S_IDLE;
            timer_r     <= TW'(0);
            half_r      <= 1'b0;
            bit_cnt_r   <= BW'(0);
            shift_r     <= 8'h00;
            hold_r      <= 8'h00;
            hold_full_r <= 1'b0;
            manch_out_r <= 1'b0;
            tx_en_r     <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            done_r <= 1'b0;

            // Ready is low whenever the register is full, so a capture never
            // coincides with the load/clear at a bit boundary below.
            if (bus.data_valid && data_ready_s) begin
                hold_r      <= bus.data_in;
                hold_full_r <= 1'b1;
            end

            case (state_r)
                S_IDLE: begin
                    manch_out_r <= 1'b0;
                    tx_en_r     <= 1'b0;
                    busy_r      <= 1'b0;
                    if (bus.start) begin
                        state_r     <= S_PREAMBLE;
                        timer_r     <= TW'(0);
                        half_r      <= 1'b0;
                        bit_cnt_r   <= BW'(0);
                        manch_out_r <= line_level(1'b1, 1'b0);
                        tx_en_r     <= 1'b1;
                        busy_r      <= 1'b1;
                    end
                end

                S_PREAMBLE, S_DATA: begin
                    if (timer_r != HALF_LAST) begin
                        timer_r <= timer_r + TW'(1);
                    end else if (!half_r) begin
                        timer_r     <= TW'(0);
                        half_r      <= 1'b1;
                        manch_out_r <= line_level(cur_bit_s, 1'b1);
                    end else begin
                        timer_r <= TW'(0);
                        half_r  <= 1'b0;
                        if (last_bit_s) begin
                            if (hold_full_r) begin
                                // Seamless hand-over: next byte starts on this very edge.
                                state_r     <= S_DATA;
                                shift_r     <= hold_r;
                                hold_full_r <= 1'b0;
                                bit_cnt_r   <= BW'(0);
                                manch_out_r <= line_level(hold_r[7], 1'b0);
                            end else begin
                                state_r     <= S_END;
                                bit_cnt_r   <= BW'(0);
                                manch_out_r <= 1'b0;
                                tx_en_r     <= 1'b0;
                            end
                        end else begin
                            bit_cnt_r <= bit_cnt_r + BW'(1);
                            if (state_r == S_DATA) begin
                                shift_r     <= {shift_r[6:0], 1'b0};
                                manch_out_r <= line_level(shift_r[6], 1'b0);
                            end else begin
                                // Next preamble bit equals the current count's LSB.
                                manch_out_r <= line_level(bit_cnt_r[0], 1'b0);
                            end
                        end
                    end
                end

                S_END: begin
                    manch_out_r <= 1'b0;
                    tx_en_r     <= 1'b0;
                    if (timer_r == END_LAST) begin
                        state_r <= S_IDLE;
                        timer_r <= TW'(0);
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else begin
                        timer_r <= timer_r + TW'(1);
                    end
                end

                default: begin
                    state_r     <= S_IDLE;
                    timer_r     <= TW'(0);
                    half_r      <= 1'b0;
                    bit_cnt_r   <= BW'(0);
                    manch_out_r <= 1'b0;
                    tx_en_r     <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end
endmodule
